// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared definitions for the memory-stage access controller:
//   - access size encodings as carried on req_size
//   - controller FSM state type
//   - alignment helper used by the error decode
package mem_access_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      RMW  = 1'b1
   } state_t;

   // True when the size is reserved or the byte offset is not naturally
   // aligned for that size.
   function automatic logic bad_size_align(input logic [1:0] size,
                                           input logic [1:0] lane);
      case (size)
         SZ_BYTE: bad_size_align = 1'b0;
         SZ_HALF: bad_size_align = lane[0];
         SZ_WORD: bad_size_align = (lane != 2'b00);
         default: bad_size_align = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Bundles the pipeline request/response handshake and the word-memory
//   port of the access controller.
//   slave  : the controller (accepts requests, drives the memory port)
//   master : the environment (pipeline drives requests, memory returns data)
//   Signals:
//     req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata
//     resp_valid/resp_err/resp_rdata
//     mem_rd/mem_wr/mem_addr/mem_wdata/mem_rdata
interface mem_access_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;

   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_err, resp_rdata,
      output mem_rd, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_err, resp_rdata,
      input  mem_rd, mem_wr, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/mem_access_ctrl_byte_lane_mux.sv
// mem_access_ctrl_byte_lane_mux
//   Purely combinational little-endian lane logic.
//   Ports:
//     lane       in  byte offset within the word (addr[1:0])
//     size       in  access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//     sign_ext   in  1 = sign-extend loaded lane, 0 = zero-extend
//     word_in    in  word read from memory
//     wdata      in  right-justified store data
//     load_data  out selected lane of word_in, extended to 32 bits
//     merge_data out word_in with the addressed lane(s) replaced by wdata
module mem_access_ctrl_byte_lane_mux
   import mem_access_ctrl_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] word_in,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // A halfword lives in the lower or upper half selected by lane[1].
   assign byte_sel = word_in[{lane, 3'b000} +: 8];
   assign half_sel = word_in[{lane[1], 4'b0000} +: 16];

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      load_data  = word_in;
      merge_data = word_in;
      case (size)
         SZ_BYTE: begin
            load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: begin
            load_data  = word_in;
            merge_data = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-stage access controller in front of a word-only data memory.
//   Loads and word stores complete in one cycle; byte/half stores become a
//   read (accept cycle) followed by a merged write (RMW cycle).
//   Ports:
//     clk    in  system clock
//     reset  in  synchronous, active-high reset
//     bus    slave modport of mem_access_ctrl_if (request, response, memory)
//   Parameters:
//     ADDR_LIMIT  byte addresses >= ADDR_LIMIT are rejected with resp_err
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_LIMIT = 256
)(
   input  logic              clk,
   input  logic              reset,
   mem_access_ctrl_if.slave  bus
);

   localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

   state_t      state;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   // Sub-word store context captured at accept, consumed in RMW.
   logic [31:0] rmw_word;
   logic [31:0] rmw_wdata;
   logic [29:0] rmw_waddr;
   logic [1:0]  rmw_lane;
   logic [1:0]  rmw_size;

   logic        accept;
   logic        req_err;
   logic        sub_store;
   logic        in_rmw;

   logic [1:0]  mux_lane;
   logic [1:0]  mux_size;
   logic [31:0] mux_word;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;

   // Reset is sampled synchronously, so an access presented in the reset
   // cycle is suppressed here to keep the memory untouched.
   assign accept    = bus.req_valid && (state == IDLE) && !reset;
   assign req_err   = bad_size_align(bus.req_size, bus.req_addr[1:0]) ||
                      (bus.req_addr >= LIMIT);
   assign sub_store = bus.req_we && (bus.req_size != SZ_WORD);
   assign in_rmw    = (state == RMW) && !reset;

   // In IDLE the mux decodes the live request (load extraction); in RMW it
   // merges the latched store into the latched word.
   assign mux_lane = (state == RMW) ? rmw_lane : bus.req_addr[1:0];
   assign mux_size = (state == RMW) ? rmw_size : bus.req_size;
   assign mux_word = (state == RMW) ? rmw_word : bus.mem_rdata;

   mem_access_ctrl_byte_lane_mux u_lane_mux (
      .lane       (mux_lane),
      .size       (mux_size),
      .sign_ext   (bus.req_signed),
      .word_in    (mux_word),
      .wdata      (rmw_wdata),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // Memory port: combinational from state and the live request.
   always_comb begin
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (in_rmw) begin
         bus.mem_wr    = 1'b1;
         bus.mem_addr  = {rmw_waddr, 2'b00};
         bus.mem_wdata = merge_data;
      end else if (accept && !req_err) begin
         bus.mem_addr = {bus.req_addr[31:2], 2'b00};
         if (bus.req_we && !sub_store) begin
            bus.mem_wr    = 1'b1;
            bus.mem_wdata = bus.req_wdata;
         end else begin
            // Loads and the read half of a sub-word store.
            bus.mem_rd = 1'b1;
         end
      end
   end

   // FSM and registered response outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state        <= IDLE;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (req_err) begin
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                  end else if (sub_store) begin
                     state <= RMW;
                  end else begin
                     resp_valid_q <= 1'b1;
                     if (!bus.req_we) resp_rdata_q <= load_data;
                  end
               end
            end
            RMW: begin
               resp_valid_q <= 1'b1;
               state        <= IDLE;
            end
         endcase
      end
   end

   // Sub-word store capture.
   // NOTE: these datapath registers have no reset; RMW is only reachable through the capture below.
   always_ff @(posedge clk) begin
      if (accept && !req_err && sub_store) begin
         rmw_word  <= bus.mem_rdata;
         rmw_wdata <= bus.req_wdata;
         rmw_waddr <= bus.req_addr[31:2];
         rmw_lane  <= bus.req_addr[1:0];
         rmw_size  <= bus.req_size;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   logic clk;
   logic reset;
   logic preload;

   int n_vec;
   int n_mis;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.ADDR_LIMIT(256)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- environment memory (64 words) ----------------
   logic [31:0] seed_mem [64];
   logic [31:0] env_mem  [64];

   assign bus.mem_rdata = env_mem[bus.mem_addr[7:2]];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) env_mem[i] <= seed_mem[i];
      end else if (bus.mem_wr) begin
         env_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      end
   end

   // ---------------- reference model: byte-addressed memory ----------------
   logic [7:0] model_mem [256];

   function automatic void model_req(input logic we, input logic [1:0] size,
                                     input logic sgn, input logic [31:0] addr,
                                     input logic [31:0] wdata,
                                     output logic exp_err, output logic [31:0] exp_rd,
                                     output int exp_lat);
      int n;
      logic [31:0] v;
      exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'd256);
      exp_rd  = 32'd0;
      exp_lat = 1;
      if (exp_err) return;
      n = 1 << size;
      if (we) begin
         for (int i = 0; i < n; i++) model_mem[addr[7:0] + 8'(i)] = wdata[8*i +: 8];
         exp_lat = (n == 4) ? 1 : 2;
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(model_mem[addr[7:0] + 8'(i)]) << (8*i));
         if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
         exp_rd = v;
      end
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one request and follow it to its response (bounded).
   task automatic apply(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err, output logic [31:0] rdata,
                        output logic acc_rd, output logic acc_wr,
                        output logic rmw_ready, output logic rmw_wr,
                        output logic [31:0] rmw_addr, output logic [31:0] rmw_wdata);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      #1;
      check("ready_at_request", bus.req_ready, 1'b1);
      check("rd_wr_exclusive", bus.mem_rd & bus.mem_wr, 1'b0);
      acc_rd    = bus.mem_rd;
      acc_wr    = bus.mem_wr;
      lat       = 0;
      err       = 1'b0;
      rdata     = 32'd0;
      rmw_ready = 1'b1;
      rmw_wr    = 1'b0;
      rmw_addr  = 32'd0;
      rmw_wdata = 32'd0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk);
         #1;
         bus.req_valid = 1'b0;
         if (bus.resp_valid) begin
            lat   = c;
            err   = bus.resp_err;
            rdata = bus.resp_rdata;
            break;
         end else if (c == 1) begin
            rmw_ready = bus.req_ready;
            rmw_wr    = bus.mem_wr;
            rmw_addr  = bus.mem_addr;
            rmw_wdata = bus.mem_wdata;
            check("rd_wr_exclusive_rmw", bus.mem_rd & bus.mem_wr, 1'b0);
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      logic        exp_rd;
      logic        exp_wr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                               input logic exp_rd, input logic exp_wr);
      vec_t v;
      v.name = name; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
      v.exp_rd = exp_rd; v.exp_wr = exp_wr;
      return v;
   endfunction

   initial begin
      int          lat, m_lat;
      logic        err, acc_rd, acc_wr, rmw_ready, rmw_wr, m_err;
      logic [31:0] rdata, rmw_addr, rmw_wdata, m_rd;

      n_vec = 0;
      n_mis = 0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      for (int i = 0; i < 64; i++) begin
         seed_mem[i] = $urandom();
         for (int b = 0; b < 4; b++) model_mem[4*i + b] = seed_mem[i][8*b +: 8];
      end

      // ---- reset state ----
      reset   = 1'b1;
      preload = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", bus.req_ready, 1'b1);
      check("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_resp_err", bus.resp_err, 1'b0);
      check("rst_resp_rdata", bus.resp_rdata, 32'd0);
      check("rst_mem_rd", bus.mem_rd, 1'b0);
      check("rst_mem_wr", bus.mem_wr, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      @(negedge clk);
      reset   = 1'b0;
      preload = 1'b0;

      // ---- table ----
      //                name       we  size  s  addr    wdata         err exp_rdata     lat rd wr
      vecs.push_back(mk("sw_beef",  1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        1, 0, 1));
      vecs.push_back(mk("lw_beef",  0, 2'd2, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 1, 1, 0));
      vecs.push_back(mk("sw_pat",   1, 2'd2, 0, 32'h20, 32'h80FF7F01, 0, 32'h0,        1, 0, 1));
      vecs.push_back(mk("lb_0",     0, 2'd0, 1, 32'h20, 32'h0,        0, 32'h00000001, 1, 1, 0));
      vecs.push_back(mk("lbu_0",    0, 2'd0, 0, 32'h20, 32'h0,        0, 32'h00000001, 1, 1, 0));
      vecs.push_back(mk("lb_1",     0, 2'd0, 1, 32'h21, 32'h0,        0, 32'h0000007F, 1, 1, 0));
      vecs.push_back(mk("lbu_1",    0, 2'd0, 0, 32'h21, 32'h0,        0, 32'h0000007F, 1, 1, 0));
      vecs.push_back(mk("lb_2",     0, 2'd0, 1, 32'h22, 32'h0,        0, 32'hFFFFFFFF, 1, 1, 0));
      vecs.push_back(mk("lbu_2",    0, 2'd0, 0, 32'h22, 32'h0,        0, 32'h000000FF, 1, 1, 0));
      vecs.push_back(mk("lb_3",     0, 2'd0, 1, 32'h23, 32'h0,        0, 32'hFFFFFF80, 1, 1, 0));
      vecs.push_back(mk("lbu_3",    0, 2'd0, 0, 32'h23, 32'h0,        0, 32'h00000080, 1, 1, 0));
      vecs.push_back(mk("lh_22",    0, 2'd1, 1, 32'h22, 32'h0,        0, 32'hFFFF80FF, 1, 1, 0));
      vecs.push_back(mk("lhu_22",   0, 2'd1, 0, 32'h22, 32'h0,        0, 32'h000080FF, 1, 1, 0));
      vecs.push_back(mk("lhu_20",   0, 2'd1, 0, 32'h20, 32'h0,        0, 32'h00007F01, 1, 1, 0));
      vecs.push_back(mk("lh_20",    0, 2'd1, 1, 32'h20, 32'h0,        0, 32'h00007F01, 1, 1, 0));
      vecs.push_back(mk("sw_1122",  1, 2'd2, 0, 32'h20, 32'h11223344, 0, 32'h0,        1, 0, 1));
      vecs.push_back(mk("sb_aa",    1, 2'd0, 0, 32'h21, 32'h000000AA, 0, 32'h0,        2, 1, 0));
      vecs.push_back(mk("lw_aa",    0, 2'd2, 0, 32'h20, 32'h0,        0, 32'h1122AA44, 1, 1, 0));
      vecs.push_back(mk("sh_hi",    1, 2'd1, 0, 32'h22, 32'h1234BEEF, 0, 32'h0,        2, 1, 0));
      vecs.push_back(mk("lw_hi",    0, 2'd2, 0, 32'h20, 32'h0,        0, 32'hBEEFAA44, 1, 1, 0));
      vecs.push_back(mk("err_lh23", 0, 2'd1, 1, 32'h23, 32'h0,        1, 32'h0,        1, 0, 0));
      vecs.push_back(mk("err_lw22", 0, 2'd2, 0, 32'h22, 32'h0,        1, 32'h0,        1, 0, 0));
      vecs.push_back(mk("err_rsvd", 0, 2'd3, 0, 32'h20, 32'h0,        1, 32'h0,        1, 0, 0));
      vecs.push_back(mk("err_oor",  0, 2'd2, 0, 32'h100,32'h0,        1, 32'h0,        1, 0, 0));
      vecs.push_back(mk("err_sh21", 1, 2'd1, 0, 32'h21, 32'h5555,     1, 32'h0,        1, 0, 0));
      vecs.push_back(mk("err_sb_oor",1,2'd0, 0, 32'h1FF,32'h77,       1, 32'h0,        1, 0, 0));
      vecs.push_back(mk("lw_top",   0, 2'd2, 0, 32'hFC, 32'h0,        0, 32'h0,        1, 1, 0));

      // The last-word load returns whatever seed data sits there; take it from the model.
      vecs[vecs.size()-1].exp_rdata = {model_mem[8'hFF], model_mem[8'hFE], model_mem[8'hFD], model_mem[8'hFC]};

      foreach (vecs[i]) begin
         apply(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
               lat, err, rdata, acc_rd, acc_wr, rmw_ready, rmw_wr, rmw_addr, rmw_wdata);
         model_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   m_err, m_rd, m_lat);
         check({vecs[i].name, "_err"}, err, vecs[i].exp_err);
         check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
         check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
         check({vecs[i].name, "_acc_rd"}, acc_rd, vecs[i].exp_rd);
         check({vecs[i].name, "_acc_wr"}, acc_wr, vecs[i].exp_wr);
         if (vecs[i].exp_lat == 2) begin
            check({vecs[i].name, "_rmw_ready"}, rmw_ready, 1'b0);
            check({vecs[i].name, "_rmw_wr"}, rmw_wr, 1'b1);
         end
      end

      // ---- sub-word store: exact RMW write word and address ----
      apply(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, lat, err, rdata,
            acc_rd, acc_wr, rmw_ready, rmw_wr, rmw_addr, rmw_wdata);
      model_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, m_err, m_rd, m_lat);
      apply(1'b1, 2'd0, 1'b0, 32'h41, 32'hFFFFFFAA, lat, err, rdata,
            acc_rd, acc_wr, rmw_ready, rmw_wr, rmw_addr, rmw_wdata);
      model_req(1'b1, 2'd0, 1'b0, 32'h41, 32'hFFFFFFAA, m_err, m_rd, m_lat);
      check("sb_seq_acc_rd", acc_rd, 1'b1);
      check("sb_seq_rmw_ready", rmw_ready, 1'b0);
      check("sb_seq_rmw_wr", rmw_wr, 1'b1);
      check("sb_seq_rmw_addr", rmw_addr, 32'h40);
      check("sb_seq_rmw_wdata", rmw_wdata, 32'h1122AA44);
      check("sb_seq_lat", lat, 2);

      // ---- reset asserted during RMW ----
      apply(1'b1, 2'd2, 1'b0, 32'h30, 32'h12345678, lat, err, rdata,
            acc_rd, acc_wr, rmw_ready, rmw_wr, rmw_addr, rmw_wdata);
      model_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h12345678, m_err, m_rd, m_lat);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_size   = 2'd1;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h30;
      bus.req_wdata  = 32'h0000BEEF;
      #1;
      check("rstrmw_acc_rd", bus.mem_rd, 1'b1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check("rstrmw_in_rmw_ready", bus.req_ready, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rstrmw_no_wr", bus.mem_wr, 1'b0);
      @(posedge clk);
      #1;
      check("rstrmw_no_resp", bus.resp_valid, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rstrmw_ready_after", bus.req_ready, 1'b1);
      check("rstrmw_no_wr_after", bus.mem_wr, 1'b0);
      @(posedge clk);
      #1;
      check("rstrmw_no_resp_after", bus.resp_valid, 1'b0);
      apply(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, lat, err, rdata,
            acc_rd, acc_wr, rmw_ready, rmw_wr, rmw_addr, rmw_wdata);
      check("rstrmw_word_kept", rdata, 32'h12345678);

      // ---- randomized requests against the model ----
      for (int n = 0; n < 400; n++) begin
         logic        r_we, r_sgn;
         logic [1:0]  r_size;
         logic [31:0] r_addr, r_wdata;
         int          r;
         r       = $urandom_range(0, 15);
         r_size  = (r == 0) ? 2'd3 : 2'(r % 3);
         r_we    = 1'($urandom_range(0, 1));
         r_sgn   = 1'($urandom_range(0, 1));
         r_wdata = $urandom();
         r_addr  = ($urandom_range(0, 9) == 0) ? ($urandom() | 32'h100)
                                               : 32'($urandom_range(0, 255));
         apply(r_we, r_size, r_sgn, r_addr, r_wdata, lat, err, rdata,
               acc_rd, acc_wr, rmw_ready, rmw_wr, rmw_addr, rmw_wdata);
         model_req(r_we, r_size, r_sgn, r_addr, r_wdata, m_err, m_rd, m_lat);
         check("rand_err", err, m_err);
         check("rand_rdata", rdata, m_rd);
         check("rand_lat", lat, m_lat);
         check("rand_no_access_on_err", m_err ? (acc_rd | acc_wr) : 1'b0, 1'b0);
      end

      // ---- final memory image ----
      for (int w = 0; w < 64; w++) begin
         check($sformatf("mem_word_%0d", w), env_mem[w],
               {model_mem[4*w+3], model_mem[4*w+2], model_mem[4*w+1], model_mem[4*w]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller sitting directly upstream of the word-only data memory. Accepts byte/halfword/word load and store requests from the pipeline and converts them into word-aligned memory reads and writes. Sub-word stores become a two-cycle read-modify-write. Loaded data is lane-extracted and sign- or zero-extended before being returned to the pipeline.

## Interface
Parameters:
- ADDR_LIMIT, 256: byte addresses >= ADDR_LIMIT are out of range.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline request present
- req_ready  out  1  controller can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: misaligned, reserved size, or out of range
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mem_addr  out  32  word-aligned address: {req_addr[31:2], 2'b00}
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data from memory (same cycle as mem_rd)

## Operation
- Byte order little-endian: byte k of a word occupies bits [8k+7:8k].
- Accept = req_valid && req_ready. req_ready = 1 only in IDLE.
- Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr >= ADDR_LIMIT. Error: no mem_rd/mem_wr issued, resp_err=1, resp_rdata=0.
- Load: mem_rd=1 in the accept cycle; selected lane extracted from mem_rdata, extended per req_signed, registered into resp_rdata.
- Word store: mem_wr=1 and mem_wdata=req_wdata in the accept cycle.
- Sub-word store: accept cycle drives mem_rd, latches mem_rdata, addr, size, wdata; goes to RMW. RMW cycle drives mem_wr with latched word, target lane(s) replaced by wdata[7:0] / wdata[15:0]; other bytes unchanged.
- FSM: IDLE -> (sub-word store accepted) RMW -> IDLE. All other accepts stay in IDLE.
- mem_rd, mem_wr never both high; both 0 when not issuing an access.

## Timing
- Reset values: FSM IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Latency, accept to resp_valid: load / word store / error = 1 cycle; sub-word store = 2 cycles.
- Throughput: loads, word stores, errors back-to-back every cycle. Sub-word store blocks 1 extra cycle (req_ready=0 in RMW).
- resp_valid is high exactly one cycle per accepted request, in order.
- mem_* outputs combinational from state and request; response outputs registered.
- Reset during RMW: write is not issued, no resp_valid, FSM returns to IDLE.
- req_valid while req_ready=0: ignored, not accepted; pipeline must hold request.

## Structure
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum (IDLE, RMW).
- One sub-module: byte_lane_mux — purely combinational; extract+extend (load) and merge (store) given addr[1:0], size, signed.
- Controller: FSM, request latches, error decode, response registers.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_wr in accept cycle; resp_rdata=0xDEADBEEF 1 cycle later, resp_err=0.
- Word 0x80FF7F01 @0x20; lb/lbu bytes 0..3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF / 0x000000FF, 0xFFFFFF80 / 0x00000080.
- Same word, lh @0x22 -> 0xFFFF80FF; lhu @0x20 -> 0x00007F01.
- sb 0xAA @0x21 onto 0x11223344 -> mem_rd then mem_wr of 0x1122AA44; req_ready=0 in RMW; resp_valid 2 cycles after accept.
- lh @0x23, lw @0x22, size 11, lw @0x100 -> resp_err=1, resp_rdata=0, no mem_rd/mem_wr.
- reset asserted in RMW of sh 0xBEEF @0x30 -> no mem_wr, no resp_valid, word unchanged; next cycle req_ready=1.
